// File: rtl/arb16_ctrl_pkg.sv
// rtl/arb16_ctrl_pkg.sv - shared constants, state encoding and helpers for arb16_ctrl
package arb16_ctrl_pkg;

  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb16_ctrl_rr_pick16.sv
// rtl/arb16_ctrl_rr_pick16.sv - circular priority pick of the first set request at or after ptr
module rr_pick16
  import arb16_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_found
);

  logic [ID_W-1:0] w_cand;

  // Scan from the far end back toward ptr so the nearest set bit is written last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = i_ptr + ID_W'(k);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb16_ctrl.sv
// rtl/arb16_ctrl.sv - 16-way round-robin arbiter with done/drop release and hold-limit timeout
module arb16_ctrl
  import arb16_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
  logic [3:0]       r_hold, w_hold_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [ID_W-1:0]  r_id, w_id_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [ID_W-1:0]  w_pick;
  logic             w_found;
  logic             w_limit;
  logic             w_owner_req;

  rr_pick16 u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_grant_nxt   = r_grant;
    w_id_nxt      = r_id;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_owner_req   = req[r_id];
    w_limit       = (MAX_HOLD != 0) && (int'(r_hold) == MAX_HOLD);

    case (r_state)
      IDLE: begin
        if (enable && w_found) begin
          w_state_nxt = BUSY;
          w_grant_nxt = id_to_onehot(w_pick);
          w_id_nxt    = w_pick;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = 4'd1;
        end
      end
      BUSY: begin
        if (done || !w_owner_req || w_limit) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_id_nxt      = '0;
          w_valid_nxt   = 1'b0;
          w_hold_nxt    = 4'd0;
          w_ptr_nxt     = r_id + ID_W'(1);
          // A coincident done or dropped request makes this an ordinary release.
          w_timeout_nxt = w_limit && !done && w_owner_req;
        end else if (r_hold != 4'hF) begin
          w_hold_nxt = r_hold + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_hold    <= 4'd0;
      r_grant   <= '0;
      r_id      <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_grant   <= w_grant_nxt;
      r_id      <= w_id_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_id;
  assign grant_valid = r_valid;
  assign timeout     = r_timeout;

endmodule
